// File: rtl/ysyx_23060025_ifu_prefetch.sv
// ysyx_23060025_ifu_prefetch: sequential prefetching IFU with a {pc, inst} fetch queue,
// redirect flush with in-flight response discard, and EBREAK halt.
module ysyx_23060025_ifu_prefetch #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int FETCH_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h3000_0000,
    parameter logic [DATA_WIDTH-1:0] EBREAK_INST = 32'h0010_0073
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             redirect_i,
    input  logic [ADDR_WIDTH-1:0]            redirect_pc_i,
    output logic                             ifu_valid_o,
    input  logic                             idu_ready_i,
    output logic [DATA_WIDTH-1:0]            if_inst_o,
    output logic [ADDR_WIDTH-1:0]            if_pc_o,
    output logic                             out_psel,
    output logic [ADDR_WIDTH-1:0]            out_paddr,
    input  logic                             out_pready,
    input  logic [DATA_WIDTH-1:0]            out_prdata,
    output logic [$clog2(FETCH_DEPTH):0]     fq_count_o,
    output logic                             halted_o
);
    localparam int PW = $clog2(FETCH_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(FETCH_DEPTH);
    typedef enum logic [1:0] {IDLE, REQ, HALT} state_t;
    state_t state, state_n;
    logic [ADDR_WIDTH-1:0] fetch_pc, fpc_n, new_pc;
    logic [ADDR_WIDTH-1:0] pc_q [FETCH_DEPTH];
    logic [DATA_WIDTH-1:0] inst_q [FETCH_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, cnt_n;
    logic discard, discard_n, enq, deq, issue;
    assign new_pc = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
    assign out_psel = state == REQ;
    assign halted_o = state == HALT;
    assign fq_count_o = count;
    assign ifu_valid_o = (count != '0) & ~redirect_i;
    assign if_pc_o = pc_q[rd_ptr];
    assign if_inst_o = inst_q[rd_ptr];
    assign deq = ifu_valid_o & idu_ready_i;
    assign enq = out_psel & out_pready & ~discard & ~redirect_i;
    assign cnt_n = redirect_i ? '0 : count + CW'(enq) - CW'(deq);
    assign fpc_n = redirect_i ? new_pc : enq ? out_paddr + ADDR_WIDTH'(4) : fetch_pc;
    // A redirect landing while a request waits must let it complete, then drop its data.
    assign discard_n = out_psel & ~out_pready & (discard | redirect_i);
    assign issue = (state_n == REQ) & ((state != REQ) | out_pready);
    always_comb begin
        state_n = state;
        if (redirect_i)
            state_n = REQ;
        else if (state == IDLE)
            state_n = cnt_n < FULL ? REQ : IDLE;
        else if (state == REQ && out_pready)
            state_n = (enq && out_prdata == EBREAK_INST) ? HALT : cnt_n < FULL ? REQ : IDLE;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            discard <= 1'b0;
            count <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            fetch_pc <= RESET_PC;
            out_paddr <= '0;
        end else begin
            state <= state_n;
            discard <= discard_n;
            count <= cnt_n;
            fetch_pc <= fpc_n;
            if (issue) out_paddr <= fpc_n;
            rd_ptr <= redirect_i ? '0 : rd_ptr + PW'(deq);
            wr_ptr <= redirect_i ? '0 : wr_ptr + PW'(enq);
        end
    end
    always_ff @(posedge clock) begin
        if (enq && !reset) begin
            pc_q[wr_ptr] <= out_paddr;
            inst_q[wr_ptr] <= out_prdata;
        end
    end
endmodule

// File: tb/tb_ysyx_23060025_ifu_prefetch.sv
// tb_ysyx_23060025_ifu_prefetch: directed bench with an icache model and an
// expected-{pc,inst} scoreboard popped on every IDU transfer.
module tb_ysyx_23060025_ifu_prefetch;
    logic clock = 1'b0, reset = 1'b1, redirect_i = 1'b0, idu_ready_i = 1'b0, out_pready = 1'b0;
    logic ebreak_on = 1'b0;
    logic [31:0] redirect_pc_i = '0, if_inst_o, if_pc_o, out_paddr, out_prdata;
    logic ifu_valid_o, out_psel, halted_o;
    logic [2:0] fq_count_o;
    int n_assert = 0, n_fail = 0;
    logic [63:0] sb [$];

    ysyx_23060025_ifu_prefetch dut (
        .clock(clock), .reset(reset), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .ifu_valid_o(ifu_valid_o), .idu_ready_i(idu_ready_i), .if_inst_o(if_inst_o),
        .if_pc_o(if_pc_o), .out_psel(out_psel), .out_paddr(out_paddr), .out_pready(out_pready),
        .out_prdata(out_prdata), .fq_count_o(fq_count_o), .halted_o(halted_o)
    );

    always #5 clock = ~clock;

    assign out_prdata = (ebreak_on && out_paddr == 32'h3000_0004) ? 32'h0010_0073 : out_paddr ^ 32'h5A5A_0013;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (ebreak_on && a == 32'h3000_0004) ? 32'h0010_0073 : a ^ 32'h5A5A_0013;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] a);
        sb.push_back({a, mem(a)});
    endtask

    task automatic accept();
        logic [63:0] e;
        chk("acc_valid", 64'(ifu_valid_o), 64'd1);
        e = sb.size() != 0 ? sb.pop_front() : '1;
        chk("acc_head", {if_pc_o, if_inst_o}, e);
        idu_ready_i = 1'b1;
        step();
        idu_ready_i = 1'b0;
    endtask

    initial begin
        step();
        step();
        chk("rst_valid", 64'(ifu_valid_o), 64'd0);
        chk("rst_psel", 64'(out_psel), 64'd0);
        chk("rst_paddr", 64'(out_paddr), 64'd0);
        chk("rst_count", 64'(fq_count_o), 64'd0);
        chk("rst_halted", 64'(halted_o), 64'd0);
        reset = 1'b0;
        out_pready = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            chk("seq_psel", 64'(out_psel), 64'd1);
            chk("seq_paddr", 64'(out_paddr), 64'(32'h3000_0000 + 32'(4 * i)));
            push(32'h3000_0000 + 32'(4 * i));
            step();
        end
        out_pready = 1'b0;
        chk("full_psel", 64'(out_psel), 64'd0);
        chk("full_count", 64'(fq_count_o), 64'd4);
        step();
        chk("full_hold_psel", 64'(out_psel), 64'd0);
        accept();
        chk("refill_psel", 64'(out_psel), 64'd1);
        chk("refill_paddr", 64'(out_paddr), 64'h3000_0010);
        chk("refill_head", 64'(if_pc_o), 64'h3000_0004);
        chk("refill_count", 64'(fq_count_o), 64'd3);

        reset = 1'b1;
        out_pready = 1'b1;
        step();
        reset = 1'b0;
        out_pready = 1'b0;
        sb.delete();
        chk("mrst_psel", 64'(out_psel), 64'd0);
        chk("mrst_count", 64'(fq_count_o), 64'd0);
        step();
        chk("mrst_req_psel", 64'(out_psel), 64'd1);
        chk("mrst_req_paddr", 64'(out_paddr), 64'h3000_0000);
        chk("mrst_req_count", 64'(fq_count_o), 64'd0);

        out_pready = 1'b1;
        push(32'h3000_0000);
        step();
        push(32'h3000_0004);
        step();
        out_pready = 1'b0;
        chk("rdw_paddr", 64'(out_paddr), 64'h3000_0008);
        redirect_i = 1'b1;
        redirect_pc_i = 32'h8000_0102;
        #1;
        chk("rdw_valid", 64'(ifu_valid_o), 64'd0);
        step();
        redirect_i = 1'b0;
        sb.delete();
        for (int i = 0; i < 2; i++) begin
            chk("rdw_hold_psel", 64'(out_psel), 64'd1);
            chk("rdw_hold_paddr", 64'(out_paddr), 64'h3000_0008);
            chk("rdw_hold_count", 64'(fq_count_o), 64'd0);
            step();
        end
        out_pready = 1'b1;
        step();
        out_pready = 1'b0;
        chk("rdw_new_paddr", 64'(out_paddr), 64'h8000_0100);
        chk("rdw_dropped", 64'(fq_count_o), 64'd0);
        out_pready = 1'b1;
        push(32'h8000_0100);
        step();
        out_pready = 1'b0;
        chk("rdw_count", 64'(fq_count_o), 64'd1);
        accept();

        out_pready = 1'b1;
        push(32'h8000_0104);
        step();
        redirect_i = 1'b1;
        redirect_pc_i = 32'h3000_0004;
        idu_ready_i = 1'b1;
        #1;
        chk("sc_valid", 64'(ifu_valid_o), 64'd0);
        step();
        redirect_i = 1'b0;
        idu_ready_i = 1'b0;
        out_pready = 1'b0;
        sb.delete();
        chk("sc_count", 64'(fq_count_o), 64'd0);
        chk("sc_paddr", 64'(out_paddr), 64'h3000_0004);
        chk("sc_valid_after", 64'(ifu_valid_o), 64'd0);

        ebreak_on = 1'b1;
        out_pready = 1'b1;
        push(32'h3000_0004);
        step();
        out_pready = 1'b0;
        chk("eb_halted", 64'(halted_o), 64'd1);
        chk("eb_psel", 64'(out_psel), 64'd0);
        chk("eb_count", 64'(fq_count_o), 64'd1);
        step();
        step();
        chk("eb_hold_psel", 64'(out_psel), 64'd0);
        chk("eb_hold_halted", 64'(halted_o), 64'd1);
        accept();
        chk("eb_drained", 64'(fq_count_o), 64'd0);
        redirect_i = 1'b1;
        redirect_pc_i = 32'h3000_0000;
        step();
        redirect_i = 1'b0;
        ebreak_on = 1'b0;
        chk("resume_halted", 64'(halted_o), 64'd0);
        chk("resume_psel", 64'(out_psel), 64'd1);
        chk("resume_paddr", 64'(out_paddr), 64'h3000_0000);
        out_pready = 1'b1;
        push(32'h3000_0000);
        step();
        out_pready = 1'b0;
        accept();

        redirect_i = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFF;
        out_pready = 1'b1;
        step();
        redirect_i = 1'b0;
        chk("wrap_paddr", 64'(out_paddr), 64'hFFFF_FFFC);
        chk("wrap_count0", 64'(fq_count_o), 64'd0);
        push(32'hFFFF_FFFC);
        step();
        out_pready = 1'b0;
        chk("wrap_next", 64'(out_paddr), 64'h0000_0000);
        chk("wrap_count1", 64'(fq_count_o), 64'd1);
        accept();
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/ysyx_23060025_ifu_prefetch.md
Name: ysyx_23060025_ifu_prefetch

Overview:
- Parametrised successor to the single-shot IFU.
- Fetches sequentially ahead of decode into a FETCH_DEPTH-entry fetch queue of {pc, inst} pairs, using the existing icache psel/paddr/pready/prdata port.
- Presents the queue head to the IDU with a valid/ready handshake.
- A redirect from EXU/CSR (branch, jump, trap, mret) flushes the queue and restarts fetch. EBREAK halts prefetch until the next redirect.

Parameters:
- ADDR_WIDTH, 32, fetch address width
- DATA_WIDTH, 32, instruction width
- FETCH_DEPTH, 4, queue entries; power of two, >= 2
- RESET_PC, 32'h3000_0000, first fetch address after reset
- EBREAK_INST, 32'h0010_0073, encoding that halts prefetch

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- redirect_i  in  1  one-cycle pulse: flush and restart fetch
- redirect_pc_i  in  ADDR_WIDTH  new fetch pc; bits [1:0] ignored (forced 0)
- ifu_valid_o  out  1  queue head valid
- idu_ready_i  in  1  IDU accepts head this cycle
- if_inst_o  out  DATA_WIDTH  head instruction
- if_pc_o  out  ADDR_WIDTH  head pc
- out_psel  out  1  icache request valid
- out_paddr  out  ADDR_WIDTH  icache request address, registered
- out_pready  in  1  icache response valid this cycle
- out_prdata  in  DATA_WIDTH  icache response data
- fq_count_o  out  clog2(FETCH_DEPTH)+1  current queue occupancy
- halted_o  out  1  prefetch stopped on EBREAK

Behaviour:
- Reset values: ifu_valid_o=0, out_psel=0, out_paddr=0, fq_count_o=0, halted_o=0, fetch_pc=RESET_PC, state=IDLE.
- Reset mid-operation clears the queue and state. An icache response arriving in the cycle reset is high is ignored.
- State IDLE:
  - Goes to REQ when not halted and fq_count < FETCH_DEPTH.
  - On entry to REQ: out_paddr <= fetch_pc, out_psel=1.
  - First request appears in the cycle after reset deasserts.
- State REQ:
  - out_psel stays 1 and out_paddr stays stable until out_pready.
  - A request is never abandoned, including on redirect.
  - On out_pready with no discard pending:
    - enqueue {out_paddr, out_prdata}
    - fetch_pc <= out_paddr + 4
    - if out_prdata == EBREAK_INST, go to HALT; else if post-update count < FETCH_DEPTH, stay in REQ with the new address (back-to-back, no bubble); else go to IDLE.
- State HALT: halted_o=1, no requests. Only redirect_i leaves HALT.
- Occupancy and issue:
  - Exactly one request outstanding at most.
  - A request is issued only when count < FETCH_DEPTH, so a returning response always has a slot.
  - Dequeue and enqueue in the same cycle keep the count unchanged.
- Enqueue latency: data returned with out_pready appears at the head the next cycle when the queue was empty. There is no combinational prdata-to-if_inst_o path.
- Output handshake:
  - ifu_valid_o = (count != 0) & ~redirect_i.
  - A transfer occurs when ifu_valid_o & idu_ready_i.
  - Head fields hold while valid and not accepted.
- Redirect (redirect_i=1):
  - Queue count <= 0; fetch_pc <= {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00}; halted_o <= 0.
  - If a request is outstanding and out_pready is 0 that cycle: set the discard flag. The matching response is dropped, not enqueued, and does not trigger EBREAK halt. On that response cycle, the next request to the redirect pc issues from the following cycle.
  - If out_pready=1 in the same cycle as redirect_i: that response is dropped. The next request is to redirect_pc from the following cycle.
  - If no request is outstanding: the request to redirect_pc issues the following cycle.
- Wrap-around: the fetch_pc increment wraps modulo 2^ADDR_WIDTH. Queue pointers wrap modulo FETCH_DEPTH.
- Simultaneous events: redirect beats dequeue and enqueue. Reset beats everything.

Test Plan:
- Reset release, icache pready every cycle -> paddr 3000_0000, _0004, _0008, _000C on consecutive cycles. idu_ready=0 -> psel drops after 4 responses; fq_count_o=4.
- Full queue, then one IDU accept -> the cycle after the dequeue, psel reasserts with paddr 3000_0010. Head pc advances to 3000_0004.
- Redirect to 8000_0102 while a request to 3000_0008 awaits pready (3 wait cycles) -> psel held, that response dropped, next paddr 8000_0100. First queued pc is 8000_0100; no stale entry.
- Redirect in the same cycle as pready and idu_ready -> ifu_valid_o=0 that cycle, nothing enqueued. fq_count_o=0 next cycle.
- Response 0010_0073 at pc 3000_0004 -> enqueued, halted_o=1, no further psel. Redirect to 3000_0000 -> halted_o=0, fetch resumes at 3000_0000.
- Assert reset for one cycle mid-request -> psel=0 and count=0 the next cycle. Fetch restarts at 3000_0000; the late pready is ignored.
